// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, round-length clamp and default widths for the memory game.
package game_pkg;

    localparam int LED_W_DEF  = 10;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [2:0] {IDLE, LOAD, SHOW, GAP, DONE} state_t;

    function automatic int clamp_len(input int len, input int seq_len);
        return (len == 0) ? 1 : ((len > seq_len) ? seq_len : len);
    endfunction

endpackage

// File: rtl/game_tick_timer.sv
// game_tick_timer: tick-qualified down-counter; expire fires on the tick that finds it at zero.
module game_tick_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         tick,
    output logic         expire
);
    logic [W-1:0] cnt;

    assign expire = en && tick && (cnt == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && tick)
            cnt <= expire ? '0 : cnt - W'(1);
    end
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: shows a round of random LED patterns with lit/blank timing and
// writes each pattern to the game register file.
module game_sequencer
    import game_pkg::*;
#(
    parameter int LED_W     = LED_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int SEQ_LEN   = 10,
    parameter int ON_TICKS  = 2,
    parameter int OFF_TICKS = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              tick,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   len,
    input  logic [LED_W-1:0]  randnum,
    output logic [LED_W-1:0]  led,
    output logic              we,
    output logic [ADDR_W-1:0] wn,
    output logic [LED_W-1:0]  d,
    output logic              busy,
    output logic              done
);
    localparam int MAX_T    = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TW       = $clog2(MAX_T + 1);
    localparam int OFF_LOAD = (OFF_TICKS > 0) ? OFF_TICKS - 1 : 0;

    state_t            state;
    logic [ADDR_W:0]   len_eff;
    logic [ADDR_W-1:0] idx;
    logic [LED_W-1:0]  val;
    logic              expire, item_end, last;

    // a blank pattern would be indistinguishable from the gap
    assign val      = (randnum == '0) ? LED_W'(1) : randnum;
    assign last     = ({1'b0, idx} + (ADDR_W+1)'(1)) == len_eff;
    assign item_end = expire && ((state == GAP) || (state == SHOW && OFF_TICKS == 0));

    game_tick_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .resetn   (resetn),
        .load     ((state == LOAD) || (state == SHOW && expire)),
        .load_val ((state == LOAD) ? TW'(ON_TICKS - 1) : TW'(OFF_LOAD)),
        .en       ((state == SHOW) || (state == GAP)),
        .tick     (tick),
        .expire   (expire)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            len_eff <= '0;
            idx     <= '0;
            led     <= '0;
            we      <= 1'b0;
            wn      <= '0;
            d       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            if (state != IDLE && abort) begin
                state <= IDLE;
                led   <= '0;
                busy  <= 1'b0;
                idx   <= '0;
            end else begin
                case (state)
                    IDLE: if (start && !abort) begin
                        len_eff <= (ADDR_W+1)'(clamp_len(int'(len), SEQ_LEN));
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end
                    LOAD: begin
                        led   <= val;
                        d     <= val;
                        wn    <= idx;
                        we    <= 1'b1;
                        state <= SHOW;
                    end
                    SHOW: if (expire) begin
                        led <= '0;
                        if (OFF_TICKS > 0)
                            state <= GAP;
                    end
                    GAP:     ;
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
                if (item_end) begin
                    if (last) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        idx   <= '0;
                    end else begin
                        idx   <= idx + ADDR_W'(1);
                        state <= LOAD;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed steps with a write scoreboard for game_sequencer.
module tb_game_sequencer;

    typedef struct packed {
        logic [3:0] wn;
        logic [9:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       tick = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [4:0] len = '0;
    logic [9:0] randnum = '0;
    logic [9:0] led, d;
    logic       we, busy, done;
    logic [3:0] wn;

    int  checks = 0;
    int  errors = 0;
    int  we_cnt = 0;
    int  done_cnt = 0;
    int  max_wn = 0;
    wr_t q[$];

    game_sequencer #(
        .LED_W(10), .ADDR_W(4), .SEQ_LEN(10), .ON_TICKS(2), .OFF_TICKS(1)
    ) dut (
        .clk(clk), .resetn(resetn), .tick(tick), .start(start), .abort(abort),
        .len(len), .randnum(randnum), .led(led), .we(we), .wn(wn), .d(d),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // scoreboard: every write must match the oldest pushed expectation
    always @(negedge clk) begin
        if (resetn && we) begin
            wr_t e;
            we_cnt++;
            if (int'(wn) > max_wn) max_wn = int'(wn);
            checks++;
            assert (q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_we: observed wn %0h with empty scoreboard", wn);
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                check("sb_wn", 32'(wn), 32'(e.wn));
                check("sb_d", 32'(d), 32'(e.d));
            end
        end
        if (resetn && done) done_cnt++;
    end

    task automatic item(input int k, input logic [9:0] v, input bit is_last, input bit poke);
        logic [9:0] ev;
        ev = (v == 10'd0) ? 10'd1 : v;
        randnum = v;
        start = poke;
        q.push_back('{wn: 4'(k), d: ev});
        step();
        check("load_we", 32'(we), 1);
        check("load_wn", 32'(wn), 32'(k));
        check("load_d", 32'(d), 32'(ev));
        check("load_led", 32'(led), 32'(ev));
        check("load_busy", 32'(busy), 1);
        step();
        check("show_we", 32'(we), 0);
        check("show_led", 32'(led), 32'(ev));
        step();
        check("gap_led", 32'(led), 0);
        start = 1'b0;
        step();
        check("end_led", 32'(led), 0);
        check("end_done", 32'(done), is_last ? 1 : 0);
        check("end_busy", 32'(busy), is_last ? 0 : 1);
        if (is_last) begin
            step();
            check("idle_done", 32'(done), 0);
            check("idle_busy", 32'(busy), 0);
        end
    endtask

    task automatic begin_round(input int lenv);
        start = 1'b1;
        len = 5'(lenv);
        step();
        start = 1'b0;
        check("start_busy", 32'(busy), 1);
        check("start_we", 32'(we), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int wc, dc, lit, dn;
        logic [9:0] v;
        // 1: reset asserted between edges, start held during reset
        start = 1'b1;
        #2 resetn = 1'b0;
        #1;
        check("rst_led", 32'(led), 0);
        check("rst_we", 32'(we), 0);
        check("rst_wn", 32'(wn), 0);
        check("rst_d", 32'(d), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        step(3);
        check("rst_hold_busy", 32'(busy), 0);
        start = 1'b0;
        resetn = 1'b1;
        step(2);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_we_cnt", 32'(we_cnt), 0);

        // 2: basic round, start pulses while busy are ignored
        wc = we_cnt; dc = done_cnt;
        begin_round(3);
        item(0, 10'h155, 1'b0, 1'b1);
        item(1, 10'h0AA, 1'b0, 1'b1);
        item(2, 10'h3FF, 1'b1, 1'b0);
        step(3);
        check("basic_writes", 32'(we_cnt - wc), 3);
        check("basic_done", 32'(done_cnt - dc), 1);
        check("basic_busy_after", 32'(busy), 0);

        // 3: zero substitution and tick gating, tick in LOAD ignored
        wc = we_cnt; dc = done_cnt;
        tick = 1'b0;
        randnum = 10'd0;
        q.push_back('{wn: 4'd0, d: 10'd1});
        begin_round(1);
        tick = 1'b1;
        step();
        check("zero_d", 32'(d), 1);
        check("zero_led", 32'(led), 1);
        lit = 1; dn = 0;
        for (int j = 0; j < 16; j++) begin
            tick = (j % 4 == 3);
            step();
            if (led != 10'd0) lit++;
            if (done) dn++;
        end
        tick = 1'b1;
        check("gated_lit_clks", 32'(lit), 8);
        check("gated_done", 32'(dn), 1);
        check("gated_writes", 32'(we_cnt - wc), 1);
        check("gated_busy", 32'(busy), 0);

        // 4: length clamping
        wc = we_cnt;
        begin_round(0);
        item(0, 10'h2C3, 1'b1, 1'b0);
        step(2);
        check("len0_writes", 32'(we_cnt - wc), 1);
        wc = we_cnt; max_wn = 0;
        begin_round(20);
        for (int k = 0; k < 10; k++) begin
            v = 10'($urandom_range(0, 1023));
            item(k, v, k == 9, 1'b0);
        end
        step(4);
        check("len20_writes", 32'(we_cnt - wc), 10);
        check("len20_max_wn", 32'(max_wn), 9);

        // 5a: abort during SHOW of item 1
        wc = we_cnt; dc = done_cnt;
        begin_round(3);
        item(0, 10'h111, 1'b0, 1'b0);
        randnum = 10'h222;
        q.push_back('{wn: 4'd1, d: 10'h222});
        step(2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_led", 32'(led), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_we", 32'(we), 0);
        step(10);
        check("abort_writes", 32'(we_cnt - wc), 2);
        check("abort_no_done", 32'(done_cnt - dc), 0);
        // 5b: abort in the LOAD cycle suppresses its write
        wc = we_cnt;
        randnum = 10'h333;
        begin_round(2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_load_we", 32'(we), 0);
        check("abort_load_busy", 32'(busy), 0);
        check("abort_load_led", 32'(led), 0);
        step(6);
        check("abort_load_writes", 32'(we_cnt - wc), 0);
        // 5c: abort beats start in IDLE
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", 32'(busy), 0);
        step(4);
        check("abort_start_writes", 32'(we_cnt - wc), 0);
        check("abort_start_done", 32'(done_cnt - dc), 0);

        // 6: async reset during GAP of item 1, then restart
        begin_round(3);
        item(0, 10'h0F0, 1'b0, 1'b0);
        randnum = 10'h00F;
        q.push_back('{wn: 4'd1, d: 10'h00F});
        step(3);
        #1 resetn = 1'b0;
        #1;
        check("mid_rst_led", 32'(led), 0);
        check("mid_rst_we", 32'(we), 0);
        check("mid_rst_wn", 32'(wn), 0);
        check("mid_rst_d", 32'(d), 0);
        check("mid_rst_busy", 32'(busy), 0);
        step();
        resetn = 1'b1;
        wc = we_cnt; dc = done_cnt;
        begin_round(2);
        item(0, 10'h1A5, 1'b0, 1'b0);
        item(1, 10'h05A, 1'b1, 1'b0);
        step(2);
        check("restart_writes", 32'(we_cnt - wc), 2);
        check("restart_done", 32'(done_cnt - dc), 1);
        check("sb_empty", 32'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
